// File: rtl/rr_arb_mux4_ctrl_if.sv
// rtl/rr_arb_mux4_ctrl_if.sv - requester/grant bundle between four requesters and the mux arbiter
interface rr_arb_mux4_ctrl_if;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic [1:0] sel;
    logic       timeout;

    modport master (output req, input gnt, input gnt_valid, input sel, input timeout);
    modport slave  (input req, output gnt, output gnt_valid, output sel, output timeout);
endinterface

// File: rtl/rr_arb_mux4_ctrl.sv
// rtl/rr_arb_mux4_ctrl.sv - round-robin 4-way arbiter driving a shared mux select; ARB_TIMEOUT_EN adds forced revoke
module rr_arb_mux4_ctrl #(
    parameter int MAX_HOLD = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rr_arb_mux4_ctrl_if.slave     bus
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state, state_nxt;
    logic [1:0] ptr, ptr_nxt;
    logic [1:0] pick;
    logic       found;
    logic       revoke;
    logic       release_now;
    logic [3:0] gnt_nxt;
    logic       gnt_valid_nxt;
    logic [1:0] sel_nxt;
    logic       timeout_nxt;

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("MAX_HOLD must be 1..255");
    end

    // Rotating search: lowest offset from ptr wins, so iterate offsets high to low.
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        for (int k = 3; k >= 0; k--) begin
            if (bus.req[ptr + 2'(k)]) begin
                found = 1'b1;
                pick  = ptr + 2'(k);
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hold_cnt <= 8'd0;
        else if (state == GRANT)
            hold_cnt <= hold_cnt + 8'd1;
        else
            hold_cnt <= 8'd0;
    end

    // sel holds the owner index for the whole GRANT state.
    assign revoke = (state == GRANT) && bus.req[bus.sel] && (hold_cnt == 8'(MAX_HOLD - 1));
`else
    assign revoke = 1'b0;
`endif

    assign release_now = (state == GRANT) && (!bus.req[bus.sel] || revoke);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            ptr           <= 2'd0;
            bus.gnt       <= 4'b0000;
            bus.gnt_valid <= 1'b0;
            bus.sel       <= 2'd0;
            bus.timeout   <= 1'b0;
        end else begin
            state         <= state_nxt;
            ptr           <= ptr_nxt;
            bus.gnt       <= gnt_nxt;
            bus.gnt_valid <= gnt_valid_nxt;
            bus.sel       <= sel_nxt;
            bus.timeout   <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found)       state_nxt = GRANT;
            GRANT:   if (release_now) state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt_nxt       = bus.gnt;
        gnt_valid_nxt = bus.gnt_valid;
        sel_nxt       = bus.sel;
        ptr_nxt       = ptr;
        timeout_nxt   = 1'b0;
        if (state == IDLE && found) begin
            gnt_nxt       = 4'b0001 << pick;
            gnt_valid_nxt = 1'b1;
            sel_nxt       = pick;
        end else if (release_now) begin
            // sel keeps the last owner so the mux output stays stable while idle.
            gnt_nxt       = 4'b0000;
            gnt_valid_nxt = 1'b0;
            ptr_nxt       = bus.sel + 2'd1;
            timeout_nxt   = revoke;
        end
    end
endmodule
